// File: rtl/vga_frame_monitor.sv
// VGA receive-side monitor: recovers line/frame timing from hsync/vsync sampled
// on pix_en, checks geometry, reports lock/errors, exports pixels and a frame checksum.
// Ports: clk/clr (async active-low), pix_en strobe, hsync/vsync/r/g/b stream, err_clr;
// outputs locked, px_valid/px_x/px_y/px_rgb (1 clk after sample), frame_done/frame_sum, h_err/v_err.
module vga_frame_monitor #(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int SYNC_POL = 0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  input  logic        err_clr,
  output logic        locked,
  output logic        px_valid,
  output logic [9:0]  px_x,
  output logic [8:0]  px_y,
  output logic [11:0] px_rgb,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic        h_err,
  output logic        v_err
);

  localparam logic       POL     = (SYNC_POL != 0);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_FIRST = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_FIRST = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0] CNT_MAX = 10'h3ff;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t      state, state_nxt;
  logic [1:0]  good, good_nxt;
  logic        locked_nxt, h_err_nxt, v_err_nxt, done_nxt;
  logic        skip_line, skip_nxt;          // first line after leaving SEARCH is not length-checked
  logic        line_bad_seen, seen_nxt;      // a bad line occurred earlier in the current frame

  logic        hs_prev, vs_prev;
  logic [9:0]  hcnt, lcnt, hcnt_nxt, lcnt_nxt;
  logic [15:0] acc;

  logic        hs_act, vs_act, h_edge, f_edge;
  logic        line_bad, frame_bad, frame_any_bad, in_active;
  logic [5:0]  rgb_sum;

  assign hs_act = (hsync == POL);
  assign vs_act = (vsync == POL);
  assign h_edge = pix_en && hs_act && !hs_prev;
  // vsync is only looked at on hsync edges, so sub-line skew between the syncs is harmless
  assign f_edge = h_edge && vs_act && !vs_prev;

  // Counts saturate; a saturated count never equals the nominal total, so it reads as an error.
  assign hcnt_nxt = h_edge ? 10'd0 : ((hcnt == CNT_MAX) ? hcnt : hcnt + 10'd1);
  assign lcnt_nxt = f_edge ? 10'd0 :
                    !h_edge ? lcnt :
                    ((lcnt == CNT_MAX) ? lcnt : lcnt + 10'd1);

  assign line_bad      = h_edge && (state != SEARCH) && !skip_line && (hcnt != H_LAST);
  assign frame_bad     = (lcnt != V_LAST);
  // a bad final line detected on the frame-edge sample belongs to the frame being closed
  assign frame_any_bad = line_bad || line_bad_seen || frame_bad;

  assign in_active = (hcnt_nxt >= H_FIRST) && (hcnt_nxt <= H_END) &&
                     (lcnt_nxt >= V_FIRST) && (lcnt_nxt <= V_END);
  assign rgb_sum   = {2'b00, r} + {2'b00, g} + {2'b00, b};

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state         <= SEARCH;
      good          <= '0;
      locked        <= 1'b0;
      h_err         <= 1'b0;
      v_err         <= 1'b0;
      frame_done    <= 1'b0;
      skip_line     <= 1'b0;
      line_bad_seen <= 1'b0;
    end else begin
      state         <= state_nxt;
      good          <= good_nxt;
      locked        <= locked_nxt;
      h_err         <= h_err_nxt;
      v_err         <= v_err_nxt;
      frame_done    <= done_nxt;
      skip_line     <= skip_nxt;
      line_bad_seen <= seen_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    good_nxt   = good;
    locked_nxt = locked;
    h_err_nxt  = h_err;
    v_err_nxt  = v_err;
    done_nxt   = 1'b0;
    skip_nxt   = skip_line;
    seen_nxt   = line_bad_seen;
    if (pix_en) begin
      // clear first so a simultaneous new error below takes priority
      if (err_clr) begin
        h_err_nxt = 1'b0;
        v_err_nxt = 1'b0;
      end
      if (h_edge) begin
        skip_nxt = 1'b0;
        if (line_bad) seen_nxt = 1'b1;
      end
      if (f_edge) begin
        seen_nxt = 1'b0;
        case (state)
          SEARCH: begin
            state_nxt = TRACK;
            good_nxt  = '0;
            skip_nxt  = 1'b1;
          end
          TRACK: begin
            done_nxt = 1'b1;
            if (frame_any_bad) begin
              good_nxt = '0;
            end else if (good == 2'd1) begin
              good_nxt   = 2'd2;
              state_nxt  = LOCKED;
              locked_nxt = 1'b1;
            end else begin
              good_nxt = good + 2'd1;
            end
          end
          LOCKED: begin
            done_nxt = 1'b1;
            if (frame_any_bad) begin
              if (line_bad || line_bad_seen) h_err_nxt = 1'b1;
              if (frame_bad) v_err_nxt = 1'b1;
              locked_nxt = 1'b0;
              good_nxt   = '0;
              state_nxt  = TRACK;
            end
          end
          default: state_nxt = SEARCH;
        endcase
      end
    end
  end

  // Sync history resets to "asserted" so a sync input idling at its asserted level
  // straight out of reset is not mistaken for an edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hs_prev   <= 1'b1;
      vs_prev   <= 1'b1;
      hcnt      <= '0;
      lcnt      <= '0;
      acc       <= '0;
      frame_sum <= '0;
      px_valid  <= 1'b0;
      px_x      <= '0;
      px_y      <= '0;
      px_rgb    <= '0;
    end else begin
      px_valid <= 1'b0;
      if (pix_en) begin
        hs_prev <= hs_act;
        if (h_edge) vs_prev <= vs_act;
        hcnt <= hcnt_nxt;
        lcnt <= lcnt_nxt;
        if (f_edge) begin
          frame_sum <= acc;
          acc       <= '0;
        end else if (in_active) begin
          acc <= acc + {10'd0, rgb_sum};
        end
        if (in_active) begin
          px_valid <= (state != SEARCH);
          px_x     <= hcnt_nxt - H_FIRST;
          px_y     <= 9'(lcnt_nxt - V_FIRST);
          px_rgb   <= {r, g, b};
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor on a reduced 20x12 geometry (sync 3/2, bp 2/2, active 12x6):
// a frame table drives the stream and holds the expected state at each frame edge;
// pixels and frame_done records go through scoreboard queues checked on the falling edge.
module tb_vga_frame_monitor;
  localparam int PD = 4;     // pix_en every 4th clk
  localparam int HT = 20;

  logic clk = 1'b0, clr = 1'b0, pix_en = 1'b0, err_clr = 1'b0;
  logic hsync = 1'b1, vsync = 1'b1, hs_p = 1'b0, vs_p = 1'b0;
  logic [3:0] r = '0, g = '0, b = '0;

  logic        locked, px_valid, frame_done, h_err, v_err;
  logic [9:0]  px_x;
  logic [8:0]  px_y;
  logic [11:0] px_rgb;
  logic [15:0] frame_sum;
  logic        locked_p, px_valid_p, frame_done_p, h_err_p, v_err_p;
  logic [9:0]  px_x_p;
  logic [8:0]  px_y_p;
  logic [11:0] px_rgb_p;
  logic [15:0] frame_sum_p;

  always #5 clk = ~clk;

  vga_frame_monitor #(.H_TOTAL(20), .H_SYNC(3), .H_BP(2), .H_ACTIVE(12), .V_TOTAL(12),
                      .V_SYNC(2), .V_BP(2), .V_ACTIVE(6), .SYNC_POL(0)) dut (
    .clk(clk), .clr(clr), .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b),
    .err_clr(err_clr), .locked(locked), .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
    .px_rgb(px_rgb), .frame_done(frame_done), .frame_sum(frame_sum), .h_err(h_err), .v_err(v_err));

  vga_frame_monitor #(.H_TOTAL(20), .H_SYNC(3), .H_BP(2), .H_ACTIVE(12), .V_TOTAL(12),
                      .V_SYNC(2), .V_BP(2), .V_ACTIVE(6), .SYNC_POL(1)) dut_p (
    .clk(clk), .clr(clr), .pix_en(pix_en), .hsync(hs_p), .vsync(vs_p), .r(r), .g(g), .b(b),
    .err_clr(err_clr), .locked(locked_p), .px_valid(px_valid_p), .px_x(px_x_p), .px_y(px_y_p),
    .px_rgb(px_rgb_p), .frame_done(frame_done_p), .frame_sum(frame_sum_p), .h_err(h_err_p),
    .v_err(v_err_p));

  // One row per transmitted frame; expectations apply at the frame edge that starts the row
  // (i.e. the edge closing the previous row).
  typedef struct {
    int          lines;   // lines in this frame
    int          long_l;  // line index sent with HT+1 samples, -1 none
    logic [11:0] pix;     // {r,g,b} on every sample
    bit          ec;      // err_clr on the starting edge sample
    int          rst_l;   // line where clr is pulsed at sample 10, -1 none
    bit          pol;     // feed the inverted stream to the SYNC_POL=1 instance
    bit          fd;      // expected frame_done at starting edge
    bit          lk, he, ve;
    logic [15:0] sum;
    bit          pfd, plk; // SYNC_POL=1 instance expectations
  } row_t;

  row_t tbl[24];
  int total = 0, bad = 0;
  bit px_on = 1'b0, p_on = 1'b0;
  logic [30:0] pq[$];
  logic [18:0] fq[$];

  function automatic row_t mk(int lines, int long_l, logic [11:0] pix, bit ec, int rst_l, bit pol,
                              bit fd, bit lk, bit he, bit ve, logic [15:0] sum, bit pfd, bit plk);
    row_t t;
    t.lines = lines; t.long_l = long_l; t.pix = pix; t.ec = ec; t.rst_l = rst_l; t.pol = pol;
    t.fd = fd; t.lk = lk; t.he = he; t.ve = ve; t.sum = sum; t.pfd = pfd; t.plk = plk;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic smp(input logic hs, input logic vs, input logic [11:0] pix, input logic ec,
                     input bit edge_chk, input int i, input bit rst);
    hsync = hs; vsync = vs;
    hs_p = p_on ? ~hs : 1'b0;
    vs_p = p_on ? ~vs : 1'b0;
    {r, g, b} = pix; err_clr = ec; pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0; err_clr = 1'b0;
    if (edge_chk || rst) begin
      @(negedge clk); #2;
    end
    if (rst) begin
      clr = 1'b0; #1;
      chk("rst_locked", locked, 0);
      chk("rst_frame_sum", frame_sum, 0);
      chk("rst_px_valid", px_valid, 0);
      chk("rst_errs", {h_err, v_err}, 0);
      px_on = 1'b0;
      pq.delete();
    end
    if (edge_chk) begin
      chk("edge_locked", locked, tbl[i].lk);
      chk("edge_h_err", h_err, tbl[i].he);
      chk("edge_v_err", v_err, tbl[i].ve);
      chk("edge_fd_missing", fq.size(), 0);
      chk("pol_frame_done", frame_done_p, tbl[i].pfd);
      chk("pol_locked", locked_p, tbl[i].plk);
      if (tbl[i].pfd) chk("pol_frame_sum", frame_sum_p, tbl[i].sum);
      else if (!tbl[i].pol) chk("pol_idle", {h_err_p, v_err_p, px_valid_p, frame_sum_p}, 0);
    end
    repeat (PD - 1) @(posedge clk);
    #1;
    if (rst) clr = 1'b1;
  endtask

  task automatic send_line(input int i, input int l, input int len, input logic [11:0] pix);
    for (int s = 0; s < len; s++) begin
      bit is_edge;
      is_edge = (l == 0) && (s == 0);
      if (px_on && s >= 5 && s <= 16 && l >= 4 && l <= 9)
        pq.push_back({10'(s - 5), 9'(l - 4), pix});
      if (is_edge && tbl[i].fd)
        fq.push_back({tbl[i].lk, tbl[i].he, tbl[i].ve, tbl[i].sum});
      smp(s >= 3, l >= 2, pix, is_edge && tbl[i].ec, is_edge, i,
          (l == tbl[i].rst_l) && (s == 10));
    end
  endtask

  initial begin
    //               lines long pix     ec rst pol fd lk he ve sum   pfd plk
    tbl[0]  = mk(12, -1, 12'h111, 0, -1, 0, 0, 0, 0, 0, 16'd0,    0, 0);
    tbl[1]  = mk(12, -1, 12'h111, 0, -1, 0, 1, 0, 0, 0, 16'd216,  0, 0);
    tbl[2]  = mk(12, -1, 12'h111, 0, -1, 0, 1, 1, 0, 0, 16'd216,  0, 0);
    tbl[3]  = mk(12, -1, 12'hfff, 0, -1, 0, 1, 1, 0, 0, 16'd216,  0, 0);
    tbl[4]  = mk(12,  5, 12'h123, 0, -1, 0, 1, 1, 0, 0, 16'd3240, 0, 0);
    tbl[5]  = mk(12, -1, 12'h111, 0, -1, 0, 1, 0, 1, 0, 16'd432,  0, 0);
    tbl[6]  = mk(12, -1, 12'h111, 0, -1, 0, 1, 0, 1, 0, 16'd216,  0, 0);
    tbl[7]  = mk(12, -1, 12'h111, 0, -1, 0, 1, 1, 1, 0, 16'd216,  0, 0);
    tbl[8]  = mk(11, -1, 12'h111, 1, -1, 0, 1, 1, 0, 0, 16'd216,  0, 0);
    tbl[9]  = mk(12, -1, 12'h111, 0, -1, 0, 1, 0, 0, 1, 16'd216,  0, 0);
    tbl[10] = mk(12, -1, 12'h111, 0, -1, 0, 1, 0, 0, 1, 16'd216,  0, 0);
    tbl[11] = mk(12, 11, 12'h111, 0, -1, 0, 1, 1, 0, 1, 16'd216,  0, 0);
    tbl[12] = mk(12, -1, 12'h111, 1, -1, 0, 1, 0, 1, 0, 16'd216,  0, 0);
    tbl[13] = mk(12, -1, 12'h111, 0, -1, 0, 1, 0, 1, 0, 16'd216,  0, 0);
    tbl[14] = mk(12, -1, 12'h111, 0, -1, 0, 1, 1, 1, 0, 16'd216,  0, 0);
    tbl[15] = mk(12, -1, 12'h111, 1, -1, 0, 1, 1, 0, 0, 16'd216,  0, 0);
    tbl[16] = mk(12, -1, 12'h111, 0,  6, 0, 1, 1, 0, 0, 16'd216,  0, 0);
    tbl[17] = mk(12, -1, 12'h111, 0, -1, 0, 0, 0, 0, 0, 16'd0,    0, 0);
    tbl[18] = mk(12, -1, 12'h111, 0, -1, 0, 1, 0, 0, 0, 16'd216,  0, 0);
    tbl[19] = mk(12, -1, 12'h111, 0, -1, 1, 1, 1, 0, 0, 16'd216,  0, 0);
    tbl[20] = mk(12, -1, 12'h111, 0, -1, 1, 1, 1, 0, 0, 16'd216,  0, 0);
    tbl[21] = mk(12, -1, 12'h111, 0, -1, 1, 1, 1, 0, 0, 16'd216,  1, 0);
    tbl[22] = mk(12, -1, 12'hfff, 0, -1, 1, 1, 1, 0, 0, 16'd216,  1, 1);
    tbl[23] = mk(12, -1, 12'h111, 0, -1, 1, 1, 1, 0, 0, 16'd3240, 1, 1);

    fork
      forever begin
        @(negedge clk);
        if (px_valid) begin
          if (pq.size() == 0) chk("px_unexpected", px_valid, 0);
          else chk("px", {px_x, px_y, px_rgb}, pq.pop_front());
        end
        if (frame_done) begin
          if (fq.size() == 0) chk("frame_done_unexpected", frame_done, 0);
          else chk("frame_done_rec", {locked, h_err, v_err, frame_sum}, fq.pop_front());
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {locked, px_valid, px_x, px_y, px_rgb, frame_done}, 0);
    chk("reset_flags", {frame_sum, h_err, v_err}, 0);
    chk("reset_outs_pol", {locked_p, px_valid_p, frame_done_p, frame_sum_p, h_err_p, v_err_p}, 0);
    clr = 1'b1;
    @(posedge clk); #1;

    // lead-in lines with vsync deasserted so the first frame edge is recognised
    send_line(0, 5, HT, 12'h000);
    send_line(0, 5, HT, 12'h000);

    for (int i = 0; i < 24; i++) begin
      px_on = 1'b1;
      p_on  = tbl[i].pol;
      for (int l = 0; l < tbl[i].lines; l++)
        send_line(i, l, (l == tbl[i].long_l) ? HT + 1 : HT, tbl[i].pix);
    end

    repeat (8) @(posedge clk);
    #1;
    chk("px_queue_drained", pq.size(), 0);
    chk("fd_queue_drained", fq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_frame_monitor.md
Name: vga_frame_monitor

Overview:
- Receive-side end of the VGA output interface (hsync, vsync, 4-bit r/g/b).
- Samples the muxed VGA stream on a pixel strobe, recovers line/frame timing, checks it against 640x480@60 geometry, and reports lock and timing errors.
- Exports per-pixel coordinates plus a per-frame pixel checksum, so game screens (maze, tetris, intro) can be checked without a monitor.
- Instantiated beside the top-level output path, or in the bench as a sink.

Parameters:
- H_TOTAL, 800, pixel samples per line
- H_SYNC, 96, hsync width in samples
- H_BP, 48, back porch samples
- H_ACTIVE, 640, visible pixels per line
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vsync width in lines
- V_BP, 33, back porch lines
- V_ACTIVE, 480, visible lines
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock
- clr  in  1  asynchronous active-low reset
- pix_en  in  1  pixel sample strobe, one clk wide (clk_n-rate tick)
- hsync  in  1  horizontal sync from VGA output
- vsync  in  1  vertical sync from VGA output
- r  in  4  red
- g  in  4  green
- b  in  4  blue
- err_clr  in  1  synchronous clear of sticky error flags
- locked  out  1  timing lock achieved
- px_valid  out  1  active-area pixel on px_* this cycle
- px_x  out  10  active column 0..639
- px_y  out  9  active row 0..479
- px_rgb  out  12  {r,g,b} of the pixel
- frame_done  out  1  one-clk pulse at the end of each complete frame
- frame_sum  out  16  sum of r+g+b over the last frame's active area, mod 2^16
- h_err  out  1  sticky: wrong line length seen
- v_err  out  1  sticky: wrong frame line count seen

Behaviour:
- Reset (clr=0, async): every output 0; counters 0; FSM=SEARCH. clr releases synchronously into SEARCH.
- All inputs are sampled only when pix_en=1. With pix_en=0, all state holds except pulse outputs.
- hsync edge: hsync is at SYNC_POL on this sample and was not on the previous sample. hcnt is set to 0 on the edge sample and otherwise increments. Line length = hcnt value before the edge + 1.
- vsync is sampled only at hsync edges. A frame edge is vsync asserted at this hsync edge and deasserted at the previous hsync edge. This tolerates sync skew of less than one line.
- lcnt is set to 0 at a frame edge and increments at every other hsync edge.
- Active area:
  - hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and lcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
  - px_x = hcnt-(H_SYNC+H_BP); px_y = lcnt-(V_SYNC+V_BP).
  - px_* are registered one clk after the sample. px_valid is 1 only in TRACK or LOCKED.
- Checksum: the accumulator (16-bit) adds r+g+b (zero-extended) for each active pixel and is cleared at a frame edge. At the frame edge, the pre-clear value is copied to frame_sum.
- Length checks: line length != H_TOTAL flags a bad line. Frame line count (lcnt+1 before the frame edge) != V_TOTAL flags a bad frame.
- Line-length check is suppressed for the first line after leaving SEARCH.
- FSM:
  - SEARCH: on the first frame edge, go to TRACK with good=0. No frame_done and no error flags in SEARCH.
  - TRACK: at each frame edge, frame_done=1 for one clk (1 clk after the sample).
    - If the frame had no bad line and no bad frame: good++. When good reaches 2, go to LOCKED and set locked=1.
    - Otherwise good=0.
  - LOCKED: at each frame edge, frame_done=1.
    - A bad line or bad frame sets h_err and/or v_err (sticky), clears locked, sets good=0, and goes to TRACK.
  - Errors in TRACK do not set h_err/v_err; only loss of lock does.
- Simultaneous events:
  - err_clr in the same clk as a new error: the error wins (flag stays 1).
  - Frame edge and a bad final line in the same sample: the line error counts toward the frame just ended.
- Sync never asserted: the block stays in SEARCH indefinitely with all outputs 0.
- Counter saturation: hcnt saturates at 1023 and lcnt at 1023. A saturated count is an error if the next edge occurs while in TRACK or LOCKED.

Test Plan:
- Reset mid-line: pulse clr low while locked -> locked=0, frame_sum=0, px_valid=0 immediately. After release, locked rises at the 3rd frame edge.
- Nominal 800x525 stream, active-low sync, pix_en every 4th clk, pixel {r,g,b}=12'h111 -> frame_done at every frame edge after the first, and locked=1 after the 3rd edge.
  - frame_sum = 307200*3 mod 65536 = 4096.
  - px_x/px_y cover 0..639/0..479, with the first px_valid at hcnt=144, lcnt=35.
- Locked stream, one line of 801 samples -> at the next frame edge locked=0 and h_err=1, v_err=0. Relock after 2 good frames; h_err stays 1 until err_clr.
- Locked stream, frame of 524 lines -> v_err=1 and locked=0 at that frame edge; h_err=0.
- err_clr asserted in the same clk as a detected bad line in LOCKED -> h_err remains 1. err_clr alone later -> h_err=0.
- SYNC_POL=1 build with an inverted-sync stream -> same lock/checksum results as the nominal case. Normal-polarity input gives no lock with locked=0.
